// File: rtl/oc8051_xrom_fetch_pkg.sv
// Shared definitions for the external program-memory fetch unit.
//   xf_state_e : bus FSM encoding (IDLE / FETCH / DRAIN, 2 bits)
package oc8051_xrom_fetch_pkg;

    typedef enum logic [1:0] {
        XfIdle  = 2'd0,
        XfFetch = 2'd1,
        XfDrain = 2'd2
    } xf_state_e;

endpackage

// File: rtl/oc8051_fetch_queue.sv
// Circular byte prefetch queue for the external fetch unit.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   flush           : clear pointers and count (priority over push/pop)
//   push, push_data : write one byte at the write pointer
//   pop_len         : bytes consumed this cycle (0 = none)
//   count           : bytes currently held
//   count_next      : count after this cycle's flush/push/pop
//   op1, op2, op3   : bytes at head, head+1, head+2 (modulo DEPTH)
module oc8051_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic [1:0]             pop_len,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next,
    output logic [7:0]             op1,
    output logic [7:0]             op2,
    output logic [7:0]             op3
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [AW-1:0] rptr_p1, rptr_p2;
    logic [CW-1:0] count_q;

    always_comb begin
        count_next = count_q + CW'(push) - CW'(pop_len);
        if (flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            mem_q   <= '{default: 8'h00};
        end else begin
            count_q <= count_next;
            if (flush) begin
                rptr_q <= '0;
                wptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= push_data;
                    wptr_q        <= wptr_q + AW'(1);
                end
                rptr_q <= rptr_q + AW'(pop_len);
            end
        end
    end

    assign rptr_p1 = rptr_q + AW'(1);
    assign rptr_p2 = rptr_q + AW'(2);

    assign count = count_q;
    assign op1   = mem_q[rptr_q];
    assign op2   = mem_q[rptr_p1];
    assign op3   = mem_q[rptr_p2];

endmodule

// File: rtl/oc8051_xrom_fetch.sv
// External program-memory fetch unit: runs byte reads on the external
// instruction bus, fills a prefetch queue and hands three bytes at a time
// to the instruction select stage.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   pc_i, pc_wr_i         : new fetch address / flush-and-restart strobe
//   istb_i, ilen_i        : instruction request and bytes consumed (0..3)
//   iack_o                : three valid head bytes while requested
//   op1_x, op2_x, op3_x   : queue head bytes 0/1/2
//   xadr_o, xstb_o        : external address and read strobe (registered)
//   xdat_i, xack_i        : external read data and cycle acknowledge
module oc8051_xrom_fetch
    import oc8051_xrom_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_i,
    input  logic        pc_wr_i,
    input  logic        istb_i,
    input  logic [1:0]  ilen_i,
    output logic        iack_o,
    output logic [7:0]  op1_x,
    output logic [7:0]  op2_x,
    output logic [7:0]  op3_x,
    output logic [15:0] xadr_o,
    output logic        xstb_o,
    input  logic [7:0]  xdat_i,
    input  logic        xack_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    xf_state_e     state_q, state_d;
    logic [15:0]   fadr_q, fadr_d;
    logic [15:0]   xadr_q, xadr_d;
    logic          xstb_q, xstb_d;
    // Fetching stays off after reset until the first PC write.
    logic          run_q, run_d;
    logic [CW-1:0] count, count_next;
    logic          push, room;
    logic [1:0]    pop_len;

    assign iack_o  = istb_i & (count >= CW'(3)) & ~pc_wr_i;
    assign pop_len = iack_o ? ilen_i : 2'd0;
    // Bytes returned in DRAIN, or overtaken by a PC write, are dropped.
    assign push    = (state_q == XfFetch) & xstb_q & xack_i & ~pc_wr_i;
    assign room    = count_next < CW'(DEPTH);

    oc8051_fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_wr_i),
        .push      (push),
        .push_data (xdat_i),
        .pop_len   (pop_len),
        .count     (count),
        .count_next(count_next),
        .op1       (op1_x),
        .op2       (op2_x),
        .op3       (op3_x)
    );

    always_comb begin
        state_d = state_q;
        fadr_d  = fadr_q;
        run_d   = run_q | pc_wr_i;
        if (pc_wr_i) begin
            fadr_d = pc_i;
        end else if (push) begin
            fadr_d = fadr_q + 16'd1;
        end
        unique case (state_q)
            XfIdle: begin
                if (pc_wr_i || (run_q && room)) begin
                    state_d = XfFetch;
                end
            end
            XfFetch: begin
                if (xack_i) begin
                    state_d = (pc_wr_i || room) ? XfFetch : XfIdle;
                end else if (pc_wr_i) begin
                    state_d = XfDrain;
                end
            end
            XfDrain: begin
                if (xack_i && !pc_wr_i) begin
                    state_d = XfFetch;
                end
            end
            default: state_d = XfIdle;
        endcase
        xstb_d = (state_d != XfIdle);
        // DRAIN keeps the abandoned cycle's address on the bus until its ack.
        xadr_d = (state_d == XfDrain) ? xadr_q : fadr_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= XfIdle;
            fadr_q  <= 16'h0000;
            xadr_q  <= 16'h0000;
            xstb_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fadr_q  <= fadr_d;
            xadr_q  <= xadr_d;
            xstb_q  <= xstb_d;
            run_q   <= run_d;
        end
    end

    assign xadr_o = xadr_q;
    assign xstb_o = xstb_q;

endmodule

// File: tb/tb_oc8051_xrom_fetch.sv
// Directed bench for oc8051_xrom_fetch with a simple wait-state ROM slave
// that returns the low address byte as data.
module tb_oc8051_xrom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_i;
    logic        pc_wr_i;
    logic        istb_i;
    logic [1:0]  ilen_i;
    logic        iack_o;
    logic [7:0]  op1_x, op2_x, op3_x;
    logic [15:0] xadr_o;
    logic        xstb_o;
    logic [7:0]  xdat_i;
    logic        xack_i;

    logic [1:0]  waits = 2'd0;
    logic [1:0]  wcnt  = 2'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    oc8051_xrom_fetch #(
        .DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_i   (pc_i),
        .pc_wr_i(pc_wr_i),
        .istb_i (istb_i),
        .ilen_i (ilen_i),
        .iack_o (iack_o),
        .op1_x  (op1_x),
        .op2_x  (op2_x),
        .op3_x  (op3_x),
        .xadr_o (xadr_o),
        .xstb_o (xstb_o),
        .xdat_i (xdat_i),
        .xack_i (xack_i)
    );

    // Slave: acks after 'waits' stall cycles, data = low address byte.
    assign xack_i = xstb_o && (wcnt == waits);
    assign xdat_i = xadr_o[7:0];
    always @(posedge clk) begin
        if (xstb_o && !xack_i) wcnt <= wcnt + 2'd1;
        else                   wcnt <= 2'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ops(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
        chk({tag, "_op1"}, op1_x, e1);
        chk({tag, "_op2"}, op2_x, e2);
        chk({tag, "_op3"}, op3_x, e3);
    endtask

    initial begin
        rst = 1'b0; pc_i = 16'h0000; pc_wr_i = 1'b0; istb_i = 1'b0; ilen_i = 2'd0;
        repeat (3) tick();
        istb_i = 1'b1;
        #1;
        chk("rst_xstb", xstb_o, 0);
        chk("rst_xadr", xadr_o, 16'h0000);
        chk("rst_iack", iack_o, 0);
        chk_ops("rst", 8'h00, 8'h00, 8'h00);
        tick(); rst = 1'b1; istb_i = 1'b0;
        repeat (3) tick();
        #1 chk("idle_no_fetch", xstb_o, 0);

        // Zero-wait fill from 0100
        tick(); pc_i = 16'h0100; pc_wr_i = 1'b1; istb_i = 1'b1;
        #1 chk("t0_iack", iack_o, 0);
        tick(); pc_wr_i = 1'b0;
        #1 chk("t1_xstb", xstb_o, 1);
        chk("t1_xadr", xadr_o, 16'h0100);
        chk("t1_iack", iack_o, 0);
        tick(); #1 chk("t2_xadr", xadr_o, 16'h0101);
        tick(); #1 chk("t3_xadr", xadr_o, 16'h0102);
        chk("t3_iack", iack_o, 0);
        tick(); #1 chk("t4_xadr", xadr_o, 16'h0103);
        chk("t4_iack", iack_o, 1);
        chk_ops("t4", 8'h00, 8'h01, 8'h02);
        tick(); #1 chk("t5_full_xstb", xstb_o, 0);
        chk("t5_iack", iack_o, 1);

        // Pop 3 from full, then pop 1 alongside a push
        tick(); ilen_i = 2'd3;
        #1 chk("t6_iack", iack_o, 1);
        chk("t6_xstb", xstb_o, 0);
        tick(); ilen_i = 2'd0;
        #1 chk("t7_xstb", xstb_o, 1);
        chk("t7_xadr", xadr_o, 16'h0104);
        chk("t7_iack", iack_o, 0);
        tick(); #1 chk("t8_xadr", xadr_o, 16'h0105);
        tick(); ilen_i = 2'd1;
        #1 chk("t9_xadr", xadr_o, 16'h0106);
        chk("t9_iack", iack_o, 1);
        chk_ops("t9", 8'h03, 8'h04, 8'h05);
        tick(); ilen_i = 2'd0;
        #1 chk("t10_xadr", xadr_o, 16'h0107);
        chk("t10_iack", iack_o, 1);
        chk_ops("t10", 8'h04, 8'h05, 8'h06);
        tick(); #1 chk("t11_full_xstb", xstb_o, 0);

        // Address wrap FFFE -> 0000; PC write masks iack on a full queue
        tick(); pc_i = 16'hFFFE; pc_wr_i = 1'b1;
        #1 chk("w0_iack_pcwr", iack_o, 0);
        tick(); pc_wr_i = 1'b0;
        #1 chk("w1_xadr", xadr_o, 16'hFFFE);
        tick(); #1 chk("w2_xadr", xadr_o, 16'hFFFF);
        tick(); #1 chk("w3_xadr", xadr_o, 16'h0000);
        tick(); #1 chk("w4_xadr", xadr_o, 16'h0001);
        chk("w4_iack", iack_o, 1);
        chk_ops("w4", 8'hFE, 8'hFF, 8'h00);
        tick(); #1 chk("w5_full_xstb", xstb_o, 0);

        // Two wait states; PC write while the 0103 cycle is pending
        waits = 2'd2;
        tick(); pc_i = 16'h0100; pc_wr_i = 1'b1;
        tick(); pc_wr_i = 1'b0;
        #1 chk("d1_xstb", xstb_o, 1);
        chk("d1_xadr", xadr_o, 16'h0100);
        repeat (6) tick();
        #1 chk("d7_iack_short", iack_o, 0);
        chk("d7_xadr", xadr_o, 16'h0102);
        repeat (3) tick();
        #1 chk("d10_iack", iack_o, 1);
        chk("d10_xadr", xadr_o, 16'h0103);
        pc_i = 16'h0200; pc_wr_i = 1'b1;
        #1 chk("d10_iack_pcwr", iack_o, 0);
        tick(); pc_wr_i = 1'b0;
        #1 chk("d11_drain_xstb", xstb_o, 1);
        chk("d11_drain_xadr", xadr_o, 16'h0103);
        tick(); #1 chk("d12_drain_xadr", xadr_o, 16'h0103);
        tick(); #1 chk("d13_xadr", xadr_o, 16'h0200);
        repeat (3) tick();
        #1 chk("d16_xadr", xadr_o, 16'h0201);
        repeat (3) tick();
        #1 chk("d19_xadr", xadr_o, 16'h0202);
        repeat (2) tick();
        #1 chk("d21_iack", iack_o, 0);
        tick(); #1 chk("d22_iack", iack_o, 1);
        chk("d22_xadr", xadr_o, 16'h0203);
        chk_ops("d22", 8'h00, 8'h01, 8'h02);
        ilen_i = 2'd1;

        // Reset mid-FETCH with two bytes queued
        tick(); ilen_i = 2'd0;
        #1 chk("d23_iack", iack_o, 0);
        chk("d23_xstb", xstb_o, 1);
        rst = 1'b0;
        tick();
        #1 chk("r_xstb", xstb_o, 0);
        chk("r_xadr", xadr_o, 16'h0000);
        chk("r_iack", iack_o, 0);
        chk_ops("r", 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        repeat (3) tick();
        #1 chk("r_stay_idle", xstb_o, 0);

        // Restart after reset
        waits = 2'd0;
        tick(); pc_i = 16'h0055; pc_wr_i = 1'b1;
        tick(); pc_wr_i = 1'b0;
        #1 chk("s1_xstb", xstb_o, 1);
        chk("s1_xadr", xadr_o, 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oc8051_xrom_fetch.md
# oc8051_xrom_fetch

External program-memory fetch unit for the oc8051 core. It runs byte-wide read cycles on the external instruction bus and keeps a small circular prefetch queue. When asked, it presents the next three instruction bytes on `op1_x`/`op2_x`/`op3_x` with an acknowledge, directly feeding the instruction select stage's `op*_x`/`istb`/`iack_i` inputs. A PC write flushes the queue and restarts fetching at the new address.

## Interface
- `DEPTH`, 4, queue depth in bytes; power of two, at least 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active low.
- `pc_i`  in  16  new fetch address; sampled when `pc_wr_i`=1.
- `pc_wr_i`  in  1  flush the queue and restart fetching at `pc_i`.
- `istb_i`  in  1  instruction request from the select stage (`istb_o` there).
- `ilen_i`  in  2  number of bytes consumed on an acknowledged request; 1..3, 0 = none.
- `iack_o`  out  1  three valid bytes at the queue head while `istb_i`=1.
- `op1_x`, `op2_x`, `op3_x`  out  8 each  queue head bytes 0/1/2.
- `xadr_o`  out  16  external ROM byte address.
- `xstb_o`  out  1  external read strobe.
- `xdat_i`  in  8  external read data; valid with `xack_i`.
- `xack_i`  in  1  external cycle acknowledge.

## Operation
- Queue state: `DEPTH`-byte storage, read pointer, write pointer (log2 DEPTH bits, wrapping), and `count` (log2 DEPTH+1 bits).
- `fadr` (16 bits) is the address of the next byte to fetch. It increments on each accepted byte and wraps FFFF->0000.
- `iack_o` = `istb_i` & (`count` >= 3) & !`pc_wr_i`, combinational.
- `op1_x..op3_x` always show head, head+1 and head+2, modulo DEPTH. Their content is don't-care unless `iack_o`=1.
- Pop: on a cycle with `iack_o`=1 and `ilen_i`!=0, the read pointer advances by `ilen_i` and `count` drops by `ilen_i`.
- Push: on a cycle with `xstb_o`&`xack_i` in state FETCH, `xdat_i` is written at the write pointer, the write pointer advances, `count` rises by 1 and `fadr` increments.
- A push and a pop in the same cycle are both applied: `count` += 1 - `ilen_i`.
- Bus FSM:
  - IDLE -> FETCH when `count_next` < DEPTH.
  - FETCH holds `xstb_o`=1 with `xadr_o`=`fadr`, both stable until `xack_i`.
  - On `xack_i` in FETCH: stay in FETCH if `count_next` < DEPTH, else go to IDLE.
  - DRAIN holds `xstb_o`=1 on the old address until `xack_i`. The data is discarded, then the FSM moves to FETCH.
- Only one bus cycle is outstanding at a time.
- `pc_wr_i` has priority over push and pop:
  - pointers and `count` clear to 0 and `fadr` <= `pc_i`;
  - from IDLE or from FETCH with `xack_i`=1, go to FETCH;
  - from FETCH with `xack_i`=0, go to DRAIN;
  - from DRAIN, stay in DRAIN.
- Queue full (`count`=DEPTH): no strobe is issued.
- Queue empty: `iack_o`=0, and `istb_i` simply waits.
- Reset (`rst`=0, any state, including mid bus cycle):
  - state IDLE, pointers/`count`/`fadr` 0, queue bytes 0;
  - `xstb_o`=0, `xadr_o`=0000, `iack_o`=0, `op*_x`=00;
  - the external slave must tolerate an abandoned cycle at reset.

## Timing
- `xstb_o` and `xadr_o` are registered. `iack_o` and `op*_x` are combinational from registered queue state plus `istb_i`/`pc_wr_i`.
- With `pc_wr_i` in cycle T from IDLE:
  - `xstb_o`=1 with `xadr_o`=`pc_i` in T+1;
  - with a zero-wait slave (`xack_i` in the same cycle as the strobe), one byte is fetched per cycle;
  - `count`=3 and `iack_o` can be 1 in T+4.
- Sustained zero-wait throughput is 1 byte/cycle. The strobe stays continuously high, and the address advances each acked cycle while `count_next` < DEPTH.
- Slave wait states: each cycle without `xack_i` adds one cycle of latency per byte.
- `pc_wr_i` in DRAIN or mid-FETCH delays the first new-address strobe until the cycle after the old cycle's `xack_i`.

## Structure
- `oc8051_defines.v` gets the FSM encodings `OC8051_XF_IDLE`, `OC8051_XF_FETCH` and `OC8051_XF_DRAIN` (2 bits).
- Sub-module `oc8051_fetch_queue` holds storage, pointers, `count`, and the push/pop/flush arithmetic, parameterised by `DEPTH`.
- The top level holds `fadr`, the bus FSM and the `iack_o` logic.

## Test plan
- Reset, then `pc_wr_i` with `pc_i`=0100 and a zero-wait slave returning `xdat_i`=low address byte -> `xadr_o` 0100, 0101, 0102, 0103, then the strobe drops (full). With `istb_i` held, `iack_o`=1 from T+4 with `op1_x..op3_x`=00,01,02.
- Queue full, `istb_i`=1, `ilen_i`=3 for one cycle -> `count` 4->1 and the strobe resumes at 0104. Next, `ilen_i`=1 in the same cycle as an acked push -> `count` unchanged.
- `pc_i`=FFFE -> fetch addresses FFFE, FFFF, 0000 (wrap). `op*_x` show the bytes from FFFE, FFFF and 0000.
- Slave with 2 wait states; `pc_wr_i` to 0200 while a cycle to 0103 is pending -> `xstb_o` stays on 0103 until ack and that data is dropped. The next strobe is on 0200, and the first acked bytes come from 0200.
- Drive `rst`=0 mid FETCH with `count`=2 -> the next cycle shows `xstb_o`=0, `xadr_o`=0000, `iack_o`=0 and `op*_x`=00. Fetching stays idle until `pc_wr_i`.
- Fewer than 3 bytes queued, or `pc_wr_i`=1 in the same cycle as `istb_i` -> `iack_o`=0 and no pop.
